// File: rtl/seq_cla_pkg.sv
// Shared definitions for the sequential carry-lookahead adder.
//
// Contents:
//   state_t   - controller states (IDLE, BUSY, DONE)
//   NIBBLE_W  - width of one lookahead slice, in bits
package seq_cla_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : seq_cla_pkg

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead adder slice, purely combinational.
//
// Ports:
//   a, b  [3:0] in   operand nibbles
//   cin         in   carry into bit 0
//   s     [3:0] out  sum nibble
//   c     [3:0] out  carry into each bit (c[0] = cin, c[3] = carry into MSB)
//   cout        out  carry out of bit 3
//   p           out  group propagate
//   g           out  group generate
//
// Every carry is a flat sum of products of the bit generate/propagate terms
// and cin, so no carry depends on a previously computed carry.
module cla4_slice
    import seq_cla_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic [NIBBLE_W-1:0] c,
    output logic                cout,
    output logic                p,
    output logic                g
);

    logic [NIBBLE_W-1:0] pb;
    logic [NIBBLE_W-1:0] gb;

    assign pb = a ^ b;
    assign gb = a & b;

    assign c[0] = cin;
    assign c[1] = gb[0] | (pb[0] & cin);
    assign c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cin);
    assign c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
                | (pb[2] & pb[1] & pb[0] & cin);

    assign p = &pb;
    assign g = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
             | (pb[3] & pb[2] & pb[1] & gb[0]);

    assign cout = g | (p & cin);
    assign s    = pb ^ c;

endmodule : cla4_slice

// File: rtl/seq_cla_adder.sv
// Sequential adder/subtractor: one 4-bit lookahead slice is reused over
// WIDTH/4 cycles, least significant nibble first.
//
// Ports:
//   clk, rst_n          clock (rising edge) and async active-low reset
//   in_valid, in_ready  operand handshake; in_ready is high only in IDLE
//   a, b, sub           operands; sub = 1 computes a - b
//   out_valid, out_ready result handshake; result held until taken
//   sum, cout, ovf      result, carry out (1 = no borrow on subtract),
//                       signed overflow
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Inputs are sampled only on an accepting edge; the result stays
// stable while out_valid is high and out_ready is low.
//
// Build option: define SEQ_CLA_ADDER_OVF_EN to compute ovf; otherwise the
// ovf port is tied to 0.
module seq_cla_adder
    import seq_cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NNIB  = WIDTH / NIBBLE_W;
    localparam int IDX_W = $clog2(NNIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NNIB - 1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_width_check
        $error("seq_cla_adder: WIDTH must be a multiple of 4 and >= 8");
    end

    state_t state, state_nx;

    logic [WIDTH-1:0]    op_a, op_b;
    logic [WIDTH-1:0]    sum_q;
    logic                carry_q;
    logic                cout_q;
    logic [IDX_W-1:0]    idx;

    logic                accept;
    logic                last_nib;

    logic [NIBBLE_W-1:0] slice_s;
    logic [NIBBLE_W-1:0] slice_c;
    logic                slice_cout;
    logic                slice_p;
    logic                slice_g;

    assign accept   = in_valid && in_ready;
    assign last_nib = (state == BUSY) && (idx == LAST_IDX);

    cla4_slice u_slice (
        .a    (op_a[idx*NIBBLE_W +: NIBBLE_W]),
        .b    (op_b[idx*NIBBLE_W +: NIBBLE_W]),
        .cin  (carry_q),
        .s    (slice_s),
        .c    (slice_c),
        .cout (slice_cout),
        .p    (slice_p),
        .g    (slice_g)
    );

    // Group P/G and the low internal carries are not needed here.
    logic unused_slice;
    assign unused_slice = ^{slice_c, slice_p, slice_g};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = BUSY;
            end
            BUSY: begin
                if (idx == LAST_IDX) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: invert b at accept and seed the carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a    <= '0;
            op_b    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx     <= '0;
        end else if (accept) begin
            op_a    <= a;
            op_b    <= b ^ {WIDTH{sub}};
            carry_q <= sub;
            idx     <= '0;
        end else if (state == BUSY) begin
            sum_q[idx*NIBBLE_W +: NIBBLE_W] <= slice_s;
            carry_q <= slice_cout;
            if (last_nib) cout_q <= slice_cout;
            else          idx    <= idx + 1'b1;  // held at last nibble, never wraps
        end
    end

`ifdef SEQ_CLA_ADDER_OVF_EN
    logic ovf_q;

    // Overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        ovf_q <= 1'b0;
        else if (last_nib) ovf_q <= slice_c[NIBBLE_W-1] ^ slice_cout;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : seq_cla_adder

// File: tb/tb_seq_cla_adder.sv
// Directed bench for seq_cla_adder (WIDTH = 16).
module tb_seq_cla_adder;

    localparam int W = 16;

`ifdef SEQ_CLA_ADDER_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int tests = 0;
    int fails = 0;

    seq_cla_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;   // value when overflow logic is built
    } vec_t;

    vec_t vecs[10];

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Present one operand pair, wait for the result, check it, then drain.
    task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs,
                         input logic [W-1:0] e_sum, input logic e_cout, input logic e_ovf,
                         input bit drain);
        int n;
        @(negedge clk);
        check("in_ready_idle", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        sub      = vs;
        @(posedge clk);
        #1;
        // Change operands after acceptance; the result must not move.
        in_valid = 1'b0;
        a        = W'($urandom_range(0, 16'hFFFF));
        b        = W'($urandom_range(0, 16'hFFFF));
        sub      = ~vs;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            #1;
            if (out_valid) break;
        end
        check("latency", n, 32'd4);
        check("sum", {16'b0, sum}, {16'b0, e_sum});
        check("cout", {31'b0, cout}, {31'b0, e_cout});
        check("ovf", {31'b0, ovf}, {31'b0, e_ovf & OVF_EN});
        if (drain) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check("out_valid_clear", {31'b0, out_valid}, 32'd0);
            check("in_ready_back", {31'b0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        logic [W-1:0] held_sum;
        logic         held_cout;
        logic         held_ovf;

        vecs[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};
        vecs[8] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_sum", {16'b0, sum}, 32'd0);
        check("rst_cout", {31'b0, cout}, 32'd0);
        check("rst_ovf", {31'b0, ovf}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].sub,
                  vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf, 1'b1);
        end

        // Stall in DONE for 10 cycles with inputs wiggling.
        do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        held_sum  = 16'h8000;
        held_cout = 1'b0;
        held_ovf  = OVF_EN;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            a        = W'($urandom_range(0, 16'hFFFF));
            b        = W'($urandom_range(0, 16'hFFFF));
            sub      = $urandom_range(0, 1) == 1;
            @(posedge clk);
            #1;
            check("stall_sum", {16'b0, sum}, {16'b0, held_sum});
            check("stall_cout", {31'b0, cout}, {31'b0, held_cout});
            check("stall_ovf", {31'b0, ovf}, {31'b0, held_ovf});
            check("stall_out_valid", {31'b0, out_valid}, 32'd1);
            check("stall_in_ready", {31'b0, in_ready}, 32'd0);
        end
        // Release with in_valid high: must go IDLE, not accept in the same cycle.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        check("release_out_valid", {31'b0, out_valid}, 32'd0);
        check("release_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b0;
        in_valid  = 1'b0;

        // Reset in the second BUSY cycle aborts the operation.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'h1234;
        b        = 16'h4321;
        sub      = 1'b0;
        @(posedge clk);          // accept
        #1;
        in_valid = 1'b0;
        @(posedge clk);          // end of first BUSY cycle
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_sum", {16'b0, sum}, 32'd0);
        check("abort_cout", {31'b0, cout}, 32'd0);
        check("abort_ovf", {31'b0, ovf}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("abort_no_result", {31'b0, out_valid}, 32'd0);
        end
        #1;
        rst_n = 1'b1;
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_seq_cla_adder
